mu_lsu: RTL and testbench

- Load/store unit on the CPU side of the multicycle MIPS data RAM.
- Accepts one load/store request at a time: lw, lh, lhu, lb, lbu, sw, sh, sb.
- Drives the RAM's word address, write data and write enable, and returns extended load data.
- The RAM has combinational read and a write on the clock edge. Sub-word stores are done as read-modify-write.

---
 rtl/mu_lsu_if.sv | 29 ++
 rtl/mu_lsu.sv | 133 +++++++++++++
 tb/tb_mu_lsu.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mu_lsu_if.sv
// rtl/mu_lsu_if.sv - request/response and RAM-side bus of the load/store unit
interface mu_lsu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_q;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_q,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_q,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mu_lsu.sv
// rtl/mu_lsu.sv - load/store unit for the multicycle MIPS data RAM
module mu_lsu #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = 32'h10010000,
  parameter int                    DEPTH_WORDS = 64
) (
  input  logic     clk,
  input  logic     reset,
  mu_lsu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [DATA_WIDTH:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [DATA_WIDTH:0] ADDR_HI = ADDR_LO + (DATA_WIDTH+1)'(4 * DEPTH_WORDS);

  state_t                state, state_nxt;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [1:0]            r_lane;
  logic [15:0]           r_wdata;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_wdata_q, rsp_rdata_q;
  logic                  rsp_error_q;

  logic                  accept, req_err, size_bad, align_bad, range_bad, word_store;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [DATA_WIDTH-1:0] ld_data, st_word;

  assign accept     = bus.req_valid && (state == IDLE);
  assign word_store = bus.req_we && (bus.req_size == 2'b10);

  // Errors are judged on the live request so an erroneous one never touches the RAM.
  assign size_bad  = (bus.req_size == 2'b11);
  assign align_bad = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign range_bad = ({1'b0, bus.req_addr} < ADDR_LO) || ({1'b0, bus.req_addr} >= ADDR_HI);
  assign req_err   = size_bad || align_bad || range_bad;

  assign bus.req_ready = (state == IDLE) && reset;
  assign bus.rsp_valid = (state == RESP) && reset;
  assign bus.mem_we    = (state == WR) && reset;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)         state_nxt = RESP;
          else if (word_store) state_nxt = WR;
          else                 state_nxt = RD;
        end
      end
      RD:      state_nxt = r_we ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Little-endian lane select on the word currently presented by the RAM.
  always_comb begin
    lane_byte = bus.mem_q[{r_lane, 3'b000} +: 8];
    lane_half = bus.mem_q[{r_lane[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   ld_data = r_unsigned ? {{(DATA_WIDTH-8){1'b0}}, lane_byte}
                                    : {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte};
      2'b01:   ld_data = r_unsigned ? {{(DATA_WIDTH-16){1'b0}}, lane_half}
                                    : {{(DATA_WIDTH-16){lane_half[15]}}, lane_half};
      default: ld_data = bus.mem_q;
    endcase
    st_word = bus.mem_q;
    if (r_size == 2'b00) st_word[{r_lane, 3'b000} +: 8]    = r_wdata[7:0];
    else                 st_word[{r_lane[1], 4'b0000} +: 16] = r_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_lane      <= 2'b00;
      r_wdata     <= '0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            r_we       <= bus.req_we;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_lane     <= bus.req_addr[1:0];
            r_wdata    <= bus.req_wdata[15:0];
            mem_addr_q <= {bus.req_addr[DATA_WIDTH-1:2], 2'b00};
            if (req_err) begin
              rsp_error_q <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (word_store) begin
              mem_wdata_q <= bus.req_wdata;
            end
          end
        end
        RD: begin
          if (r_we) begin
            mem_wdata_q <= st_word;
          end else begin
            rsp_rdata_q <= ld_data;
            rsp_error_q <= 1'b0;
          end
        end
        WR: begin
          rsp_rdata_q <= '0;
          rsp_error_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mu_lsu.sv
// tb/tb_mu_lsu.sv - directed self-checking bench for mu_lsu
module tb_mu_lsu;
  localparam logic [31:0] BASE = 32'h10010000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mu_lsu_if #(.DATA_WIDTH(32)) bus ();

  mu_lsu #(.DATA_WIDTH(32), .BASE_ADDR(BASE), .DEPTH_WORDS(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] ram [64];
  logic [31:0] ram_off;
  assign ram_off    = bus.mem_addr - BASE;
  assign bus.mem_q  = ram[ram_off[7:2]];

  int          we_cnt = 0;
  int          rsp_cnt = 0;
  int          acc_cnt = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      ram[ram_off[7:2]] <= bus.mem_wdata;
      we_cnt++;
      last_waddr = bus.mem_addr;
      last_wdata = bus.mem_wdata;
    end
    if (bus.rsp_valid) rsp_cnt++;
    if (bus.req_valid && bus.req_ready) acc_cnt++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    bit found = 0;
    rdata = '0;
    err   = 1'b0;
    lat   = 0;
    @(negedge clk);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    for (int i = 0; i < 5 && !bus.req_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 1; i <= 8 && !found; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        found = 1;
        lat   = i;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_error;
      end
    end
    if (!found) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          we0, rsp0, acc0;
  logic [8:0]  pat;

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = BASE;
    bus.req_wdata    = '0;

    repeat (3) @(negedge clk);
    check("rst_ready_low", 32'(bus.req_ready), 32'd0);
    check("rst_mem_addr",  bus.mem_addr, BASE);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    reset = 1'b1;
    #1 check("idle_ready", 32'(bus.req_ready), 32'd1);
    check("idle_we", 32'(bus.mem_we), 32'd0);

    we0 = we_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h10010004, 32'hDEADBEEF, rd, er, lat);
    check("sw_we_pulses", 32'(we_cnt - we0), 32'd1);
    check("sw_waddr", last_waddr, 32'h10010004);
    check("sw_wdata", last_wdata, 32'hDEADBEEF);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_err", 32'(er), 32'd0);
    check("sw_rdata", rd, 32'd0);

    do_req(1'b0, 2'b10, 1'b0, 32'h10010004, 32'd0, rd, er, lat);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", 32'(er), 32'd0);
    check("lw_lat", 32'(lat), 32'd2);

    do_req(1'b1, 2'b00, 1'b0, 32'h10010006, 32'hFFFFFF11, rd, er, lat);
    check("sb_wdata", last_wdata, 32'hDE11BEEF);
    check("sb_lat", 32'(lat), 32'd3);
    do_req(1'b1, 2'b01, 1'b0, 32'h10010004, 32'h99992233, rd, er, lat);
    check("sh_wdata", last_wdata, 32'hDE112233);
    check("sh_lat", 32'(lat), 32'd3);

    do_req(1'b1, 2'b10, 1'b0, 32'h10010008, 32'h00008080, rd, er, lat);
    do_req(1'b0, 2'b00, 1'b0, 32'h10010008, 32'd0, rd, er, lat);
    check("lb", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h10010008, 32'd0, rd, er, lat);
    check("lbu", rd, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b0, 32'h10010008, 32'd0, rd, er, lat);
    check("lh", rd, 32'hFFFF8080);
    do_req(1'b0, 2'b01, 1'b1, 32'h10010008, 32'd0, rd, er, lat);
    check("lhu", rd, 32'h00008080);
    do_req(1'b0, 2'b00, 1'b0, 32'h10010007, 32'd0, rd, er, lat);
    check("lb_lane3", rd, 32'hFFFFFFDE);

    do_req(1'b0, 2'b01, 1'b0, 32'h10010001, 32'd0, rd, er, lat);
    check("lh_mis_err", 32'(er), 32'd1);
    check("lh_mis_rdata", rd, 32'd0);
    check("lh_mis_lat", 32'(lat), 32'd1);
    we0 = we_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h10010100, 32'h12345678, rd, er, lat);
    check("sw_oor_err", 32'(er), 32'd1);
    check("sw_oor_no_we", 32'(we_cnt - we0), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h1000FFFC, 32'd0, rd, er, lat);
    check("lw_low_err", 32'(er), 32'd1);
    do_req(1'b0, 2'b11, 1'b0, 32'h10010000, 32'd0, rd, er, lat);
    check("size11_err", 32'(er), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h100100FC, 32'd0, rd, er, lat);
    check("lw_top_ok", 32'(er), 32'd0);

    // Reset pulled low during the WR cycle of a byte store.
    @(negedge clk);
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h10010006;
    bus.req_wdata = 32'h00000055;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    we0  = we_cnt;
    rsp0 = rsp_cnt;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_wr", 32'(bus.mem_we), 32'd1);
    reset = 1'b0;
    #1 check("rst_we_gated", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rel_ready", 32'(bus.req_ready), 32'd1);
    check("rel_mem_addr", bus.mem_addr, BASE);
    repeat (3) @(negedge clk);
    check("rel_no_we", 32'(we_cnt - we0), 32'd0);
    check("rel_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10010004, 32'd0, rd, er, lat);
    check("rel_word_kept", rd, 32'hDE112233);

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10010008;
    bus.req_valid    = 1'b1;
    acc0 = acc_cnt;
    rsp0 = rsp_cnt;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      pat[i-1] = bus.req_ready;
    end
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_ready_pat", 32'(pat), 32'h124);
    check("b2b_accepts", 32'(acc_cnt - acc0), 32'd3);
    check("b2b_rsps", 32'(rsp_cnt - rsp0), 32'd3);
    check("b2b_rdata", bus.rsp_rdata, 32'h00008080);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
